// File: rtl/l1_pkg.sv
// Shared constants and types for the layer-1 window read path.
// Geometry of the 13x13 feature buffer, tap word type and the
// read sequencer state encoding.
package l1_pkg;

  localparam int unsigned IMG_W = 13;
  localparam int unsigned IMG_H = 13;
  localparam int unsigned DW    = 18;
  localparam int unsigned AW    = 8;
  localparam int unsigned TAPS  = 9;
  localparam int unsigned RCW   = 4;  // row/col counter width

  // First anchor is the bottom-right pixel of the top-left 3x3 window.
  localparam int unsigned FIRST_ANCHOR = 2 * IMG_W + 2;
  localparam int unsigned LAST_ANCHOR  = IMG_W * IMG_H - 1;

  typedef logic [DW-1:0] tap_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LAST,
    ST_DONE
  } state_e;

endpackage

// File: rtl/l1_anchor_counter.sv
// Anchor address generator for the layer-1 window scan.
// Keeps the buffer address of the current 3x3 anchor (bottom-right tap)
// together with its pixel row/column, and steps it in raster order over
// the valid anchors only (columns/rows 2..N-1).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : reload the first anchor (row 2, col 2)
//   advance_i  : step to the next anchor
//   addr_o     : anchor buffer address
//   row_o      : anchor pixel row
//   col_o      : anchor pixel column
//   last_o     : current anchor is the final one of the frame
module l1_anchor_counter
  import l1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           advance_i,
  output logic [AW-1:0]  addr_o,
  output logic [RCW-1:0] row_o,
  output logic [RCW-1:0] col_o,
  output logic           last_o
);

  logic [AW-1:0]  addr_q, addr_d;
  logic [RCW-1:0] row_q,  row_d;
  logic [RCW-1:0] col_q,  col_d;

  always_comb begin
    addr_d = addr_q;
    row_d  = row_q;
    col_d  = col_q;
    if (load_i) begin
      addr_d = AW'(FIRST_ANCHOR);
      row_d  = RCW'(2);
      col_d  = RCW'(2);
    end else if (advance_i) begin
      if (col_q == RCW'(IMG_W - 1)) begin
        // Jump over columns 0..1 of the next row: no anchor exists there.
        addr_d = addr_q + AW'(3);
        col_d  = RCW'(2);
        row_d  = row_q + RCW'(1);
      end else begin
        addr_d = addr_q + AW'(1);
        col_d  = col_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= AW'(FIRST_ANCHOR);
      row_q  <= RCW'(2);
      col_q  <= RCW'(2);
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign addr_o = addr_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (addr_q == AW'(LAST_ANCHOR));

endmodule

// File: rtl/l1_window_reader.sv
// Read-side sequencer for the 13x13 layer-1 feature buffer.
// On start, walks every valid 3x3 anchor in raster order, registers the
// nine combinational buffer taps and hands each window downstream over a
// valid/ready handshake (one window per handshake), then pulses done.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a frame scan (ignored unless idle)
//   busy       : scan in progress
//   done       : one-cycle pulse after the last window is accepted
//   addr_rd    : anchor address to the buffer
//   taps_in    : buffer taps, [0]=top-left .. [8]=bottom-right (anchor)
//   win_valid  : win_data holds a window
//   win_ready  : downstream accept
//   win_data   : registered taps, same ordering as taps_in
//   win_row    : output-map row of win_data
//   win_col    : output-map column of win_data
module l1_window_reader
  import l1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  addr_rd,
  input  tap_t           taps_in   [TAPS-1:0],
  output logic           win_valid,
  input  logic           win_ready,
  output tap_t           win_data  [TAPS-1:0],
  output logic [RCW-1:0] win_row,
  output logic [RCW-1:0] win_col
);

  state_e state_q, state_d;

  logic [RCW-1:0] ctr_row, ctr_col;
  logic           at_last;
  logic           ctr_load, ctr_advance;
  logic           load_evt, hs;

  logic           win_valid_q, win_valid_d;
  tap_t           win_data_q [TAPS-1:0];
  tap_t           win_data_d [TAPS-1:0];
  logic [RCW-1:0] win_row_q, win_row_d;
  logic [RCW-1:0] win_col_q, win_col_d;

  l1_anchor_counter u_anchor (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ctr_load),
    .advance_i (ctr_advance),
    .addr_o    (addr_rd),
    .row_o     (ctr_row),
    .col_o     (ctr_col),
    .last_o    (at_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)              state_d = ST_SCAN;
      ST_SCAN: if (load_evt && at_last) state_d = ST_LAST;
      ST_LAST: if (hs)                 state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    hs          = win_valid_q && win_ready;
    ctr_load    = 1'b0;
    load_evt    = 1'b0;
    ctr_advance = 1'b0;
    busy        = (state_q == ST_SCAN) || (state_q == ST_LAST);
    done        = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: ctr_load = start;
      ST_SCAN: begin
        // Output register is free when empty or being drained this cycle.
        load_evt    = !win_valid_q || win_ready;
        // The final anchor is captured in place; the counter parks on it.
        ctr_advance = load_evt && !at_last;
      end
      default: ;
    endcase
  end

  // Window output register next-state
  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (load_evt) begin
      win_valid_d = 1'b1;
      win_data_d  = taps_in;
      win_row_d   = ctr_row - RCW'(2);
      win_col_d   = ctr_col - RCW'(2);
    end else if ((state_q == ST_LAST) && hs) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_data_q  <= '{default: '0};
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_l1_window_reader.sv
module tb_l1_window_reader;
  import l1_pkg::*;

  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic [AW-1:0]  addr_rd;
  tap_t           taps_in  [TAPS-1:0];
  logic           win_valid;
  logic           win_ready;
  tap_t           win_data [TAPS-1:0];
  logic [RCW-1:0] win_row;
  logic [RCW-1:0] win_col;

  l1_window_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .addr_rd   (addr_rd),
    .taps_in   (taps_in),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col)
  );

  always #5 clk = ~clk;

  // Buffer model: flat pixel memory, padded so any address offset is legal.
  tap_t ram [0:255];

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      taps_in[k] = ram[(int'(addr_rd) + 256 - (2 - k / 3) * IMG_W - (2 - k % 3)) % 256];
    end
  end

  typedef struct packed {
    logic [TAPS-1:0][DW-1:0] t;
    logic [3:0]              row;
    logic [3:0]              col;
  } win_t;

  win_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int frames_done = 0;
  int mode = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: every 3x3 window of the image in raster order.
  task automatic push_expected();
    win_t w;
    for (int r = 0; r < IMG_H - 2; r++) begin
      for (int c = 0; c < IMG_W - 2; c++) begin
        for (int k = 0; k < 9; k++) begin
          w.t[k] = ram[(r + k / 3) * IMG_W + c + k % 3];
        end
        w.row = 4'(r);
        w.col = 4'(c);
        exp_q.push_back(w);
      end
    end
  endtask

  // Ready driver
  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mode == 0) begin
        win_ready = 1'b1;
      end else if (hs_cnt == 3 && stall_cnt < 5) begin
        win_ready = 1'b0;
        stall_cnt++;
      end else begin
        win_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int   done_due = 0;
    bit   prev_stall = 0;
    tap_t sv_data [TAPS-1:0];
    logic [3:0] sv_row, sv_col;
    logic [AW-1:0] sv_addr;
    win_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due   = 0;
        prev_stall = 0;
      end else begin
        if (done_due == 1) begin
          check("done_pulse", done, 1);
          check("busy_at_done", busy, 0);
          frames_done++;
          done_due = 2;
        end else if (done_due == 2) begin
          check("done_width", done, 0);
          done_due = 0;
        end else if (done) begin
          check("unexpected_done", done, 0);
        end

        if (prev_stall && win_valid) begin
          for (int k = 0; k < 9; k++) check($sformatf("stall_data[%0d]", k), win_data[k], sv_data[k]);
          check("stall_row", win_row, sv_row);
          check("stall_col", win_col, sv_col);
          check("stall_addr", addr_rd, sv_addr);
        end

        if (win_valid && win_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_window", 1, 0);
          end else begin
            w = exp_q.pop_front();
            for (int k = 0; k < 9; k++)
              check($sformatf("win%0d_tap[%0d]", hs_cnt, k), win_data[k], w.t[k]);
            check($sformatf("win%0d_row", hs_cnt), win_row, w.row);
            check($sformatf("win%0d_col", hs_cnt), win_col, w.col);
          end
          hs_cnt++;
          if (hs_cnt == NWIN) done_due = 1;
        end

        prev_stall = win_valid && !win_ready;
        sv_data = win_data;
        sv_row  = win_row;
        sv_col  = win_col;
        sv_addr = addr_rd;
      end
    end
  end

  task automatic run_frame(input int m, input bit seq, input int restart_at, input int abort_at);
    int fd0;
    bit finished;
    for (int i = 0; i < 256; i++) begin
      if (i >= IMG_W * IMG_H) ram[i] = '0;
      else if (seq)           ram[i] = tap_t'(i);
      else                    ram[i] = tap_t'($urandom);
    end
    exp_q.delete();
    push_expected();
    mode      = m;
    stall_cnt = 0;
    hs_cnt    = 0;
    fd0       = frames_done;
    finished  = 0;

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_addr", addr_rd, FIRST_ANCHOR);
    check("start_busy", busy, 1);
    check("start_valid_low", win_valid, 0);
    @(posedge clk); #1;
    check("first_valid", win_valid, 1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      start = (restart_at > 0 && cyc == restart_at);
      if (abort_at > 0 && hs_cnt >= abort_at) begin
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", win_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", addr_rd, FIRST_ANCHOR);
        check("abort_row", win_row, 0);
        check("abort_col", win_col, 0);
        exp_q.delete();
        hs_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        return;
      end
      if (frames_done != fd0) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    check("frame_finished", finished, 1);
    check("handshake_count", hs_cnt, NWIN);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", win_valid, 0);
    check("rst_addr", addr_rd, FIRST_ANCHOR);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    for (int k = 0; k < 9; k++) check($sformatf("rst_data[%0d]", k), win_data[k], 0);

    run_frame(0, 1, 0, 0);    // ram[i]=i, ready held high
    run_frame(1, 1, 0, 0);    // same image with stall at window 3 and random ready
    run_frame(1, 0, 0, 0);    // random image, random ready
    run_frame(0, 0, 40, 0);   // start re-pulsed mid-scan
    run_frame(1, 0, 0, 50);   // reset at window 50, frame abandoned
    run_frame(1, 0, 0, 0);    // full frame after abort
    run_frame(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_window_reader.md
Name: l1_window_reader

Overview:
- Read-side sequencer for the 13x13 layer-1 feature buffer. The buffer is written pixel by pixel and exposes a combinational 3x3 tap window anchored at `addr_rd`, where `addr_rd` is the bottom-right pixel.
- On `start`, this block scans every valid anchor in raster order and drives `addr_rd`.
- It registers the nine taps and presents them downstream with a valid/ready handshake, one window per handshake.
- It sits between the layer-1 buffer and the layer-2 convolution MAC array.

Parameters:
- IMG_W, 13, feature-map width in pixels.
- IMG_H, 13, feature-map height in pixels.
- DW, 18, tap data width in bits.
- AW, 8, buffer address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a frame scan; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done is asserted.
- done  out  1  one-cycle pulse after the last window is accepted.
- addr_rd  out  AW  anchor address to the buffer.
- taps_in  in  DW x 9 (unpacked [8:0])  combinational buffer taps. Index 0 is top-left, 8 is bottom-right (the anchor).
- win_valid  out  1  win_data holds a valid window.
- win_ready  in  1  downstream accepts when win_valid && win_ready.
- win_data  out  DW x 9 (unpacked [8:0])  registered taps, same ordering as taps_in.
- win_row  out  4  output-map row of win_data, 0..IMG_H-3.
- win_col  out  4  output-map column of win_data, 0..IMG_W-3.

Behaviour:
- Reset values: `busy`=0, `done`=0, `win_valid`=0, `win_data`=all 0, `win_row`=0, `win_col`=0, `addr_rd`=2*IMG_W+2 (28), FSM=IDLE.
- FSM states: IDLE, SCAN, LAST, DONE.
  - IDLE: start=1 moves to SCAN. Load `addr_rd`=28 and internal row/col = 2/2.
  - SCAN: on each load event, capture taps_in into win_data. Set win_valid=1. Set win_row=row-2, win_col=col-2. Then advance the anchor.
  - A load event is (!win_valid || win_ready).
  - When the anchor being captured is (IMG_H-1, IMG_W-1), i.e. addr 168, capture it and go to LAST; do not advance.
  - LAST: wait for the handshake of the final window. On it, clear win_valid and go to DONE.
  - DONE: pulse done=1 for one cycle, then return to IDLE. busy=0 in the same cycle done is high.
- Anchor advance:
  - col < IMG_W-1: addr_rd+1, col+1.
  - col == IMG_W-1: addr_rd+3, col=2, row+1. This skips columns 0..1 of the next row.
  - All arithmetic is AW-bit unsigned. The maximum address, 168, fits in 8 bits and never wraps.
- Latency:
  - start at cycle T gives addr_rd=28 valid at T+1.
  - win_valid rises at T+2.
  - With win_ready held high, one window per cycle, 121 windows in total (11x11).
  - done pulses at the cycle after the 121st handshake.
- Backpressure:
  - While win_valid && !win_ready, win_data, win_row, win_col and addr_rd are held.
  - No tap is skipped or duplicated.
- Buffer contents must not change during a scan; the writer is gated by busy externally.
- A start pulse while busy or in DONE is ignored.
- rst asserted in any state returns all outputs to reset values next cycle, including mid-scan and in LAST. A partially delivered frame is abandoned and no done pulse is produced.
- win_ready while win_valid=0 has no effect.

Decomposition:
- Shared package l1_pkg holds:
  - constants IMG_W, IMG_H, DW, AW, TAPS=9;
  - FIRST_ANCHOR = 2*IMG_W+2 and LAST_ANCHOR = IMG_W*IMG_H-1;
  - typedef tap_t = logic [DW-1:0];
  - the FSM state enum.
- One sub-module is natural: l1_anchor_counter (row/col/addr counters with advance and wrap).
- The FSM and output register stay in the top.

Test Plan:
- Model the buffer with ram[i]=i, start, win_ready=1 → first window at start+2:
  - taps {0,1,2,13,14,15,26,27,28};
  - win_row=0, win_col=0.
- Same run, window 11 then window 12:
  - window 11 has anchor 38, taps ending {..,36,37,38}, win_col=10;
  - window 12 has addr_rd=41, taps {13,14,15,26,27,28,39,40,41}, win_row=1, win_col=0.
- Full frame with win_ready=1:
  - exactly 121 handshakes;
  - last taps {140,141,142,153,154,155,166,167,168};
  - done is a single pulse the cycle after; busy falls with it.
- Backpressure: win_ready low for 5 cycles at window 3, plus random toggling:
  - win_data is stable while stalled;
  - the sequence is identical to the no-stall run;
  - still 121 windows.
- start re-pulsed mid-scan → ignored; count and sequence unchanged.
- rst asserted at window 50 → next cycle win_valid=0, busy=0, addr_rd=28, and no done. A subsequent start delivers a full, correct 121-window frame.
